// File: rtl/sa_pkg.sv
// Shared types and constants for the 3x3 weight-stationary systolic array
// and its companion blocks.
package sa_pkg;

  localparam int SA_DATA_W = 8;
  localparam int SA_COLS   = 3;

  typedef logic [SA_DATA_W-1:0] psum_t;
  typedef psum_t [SA_COLS-1:0]  psum_row_t;

endpackage

// File: rtl/sa_row_fifo.sv
// Small synchronous FIFO for aligned result rows. The head entry is shown
// combinationally on data_o. When the FIFO is empty, data_o shows the last
// head that was on display, so the output holds its value instead of
// exposing stale memory. Clear empties the FIFO and zeroes that held value.
module sa_row_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = empty_o ? hold_q : mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Next pointer, level and held-output values; clear wins over traffic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    hold_d   = data_o;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      hold_d   = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      level_d = level_q + LVL_W'(1);
      else if (!push_ok && pop_ok) level_d = level_q - LVL_W'(1);
    end
  end

  // Pointer, level and held-output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
    end
  end

  // Row storage; written only on an accepted push outside a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok && !clear_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/sa_psum_collector.sv
// Output-side collector for the 3x3 weight-stationary array. It de-skews
// the column-staggered bottom-row partial sums into whole rows, buffers
// them in a small FIFO and hands them downstream on valid/ready. out_last
// marks the final row of each tile.
// Optional build macro SA_COLLECT_RELU_EN: clamps negative lanes (MSB set)
// to zero as rows enter the FIFO.
module sa_psum_collector
  import sa_pkg::*;
#(
  parameter int DATA_W     = SA_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TILE_ROWS  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        row_valid_in,
  input  logic [DATA_W-1:0]           psum_in1,
  input  logic [DATA_W-1:0]           psum_in2,
  input  logic [DATA_W-1:0]           psum_in3,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SA_COLS*DATA_W-1:0]   out_row,
  output logic                        out_last,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);

  localparam int CNT_W = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;

  logic [DATA_W-1:0]              p1_d1_q, p1_d2_q, p2_d1_q;
  logic                           vld_d1_q, vld_d1_d;
  logic                           vld_d2_q, vld_d2_d;
  logic [SA_COLS-1:0][DATA_W-1:0] row_d;
  logic                           push_v;
  logic                           pop;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic [CNT_W-1:0]               tile_cnt_q, tile_cnt_d;
  logic                           overflow_q, overflow_d;

  // Skew-pipeline valids; a clear drops anything still in flight.
  always_comb begin
    vld_d1_d = row_valid_in;
    vld_d2_d = vld_d1_q;
    if (clear) begin
      vld_d1_d = 1'b0;
      vld_d2_d = 1'b0;
    end
  end

  // Skew-pipeline valid registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_d1_q <= 1'b0;
      vld_d2_q <= 1'b0;
    end else begin
      vld_d1_q <= vld_d1_d;
      vld_d2_q <= vld_d2_d;
    end
  end

  // Column 1 waits two cycles and column 2 one, to line up with column 3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_d1_q <= '0;
      p1_d2_q <= '0;
      p2_d1_q <= '0;
    end else begin
      p1_d1_q <= psum_in1;
      p1_d2_q <= p1_d1_q;
      p2_d1_q <= psum_in2;
    end
  end

  assign push_v = vld_d2_q;

  // Assemble the aligned row, col1 in the low lane.
  always_comb begin
    row_d[0] = p1_d2_q;
    row_d[1] = p2_d1_q;
    row_d[2] = psum_in3;
`ifdef SA_COLLECT_RELU_EN
    for (int i = 0; i < SA_COLS; i++) begin
      if (row_d[i][DATA_W-1]) row_d[i] = '0;
    end
`endif
  end

  sa_row_fifo #(
    .WIDTH (SA_COLS*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .clear_i (clear),
    .push_i  (push_v),
    .pop_i   (pop),
    .data_i  (row_d),
    .data_o  (out_row),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && (tile_cnt_q == CNT_W'(TILE_ROWS-1));

  // Tile counter advances on every pop and wraps after the last tile row;
  // a row arriving at a full FIFO with no pop is dropped and flagged.
  always_comb begin
    tile_cnt_d = tile_cnt_q;
    overflow_d = overflow_q;
    if (clear) begin
      tile_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (pop) begin
        if (tile_cnt_q == CNT_W'(TILE_ROWS-1)) tile_cnt_d = '0;
        else                                   tile_cnt_d = tile_cnt_q + CNT_W'(1);
      end
      if (push_v && fifo_full && !pop) overflow_d = 1'b1;
    end
  end

  // Tile counter and sticky overflow registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tile_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      tile_cnt_q <= tile_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

endmodule
